aes256_cbc_pkcs7_pad: RTL and testbench
=======================================

// Module: aes256_cbc_pkcs7_pad
// PURPOSE
//  Upstream stage of aes256_cbc_comb: takes one AXI-Stream packet per message
//  (key, IV, byte-granular payload) and emits the same packet block-aligned.
//  Encrypt: appends PKCS#7 padding (1..16 bytes of value p) to fill the last block.
//  Decrypt: passes payload through and flags, then zero-fills, any length that is
//  not a whole number of blocks.
// PARAMETERS
//  AXIS_WIDTH  64  S/M tdata width in bits; legal 64 or 128 (elab assert otherwise)
// PORTS
//  Clk            in   1             clock
//  Rst            in   1             sync reset, active-high
//  S_axis_tvalid  in   1             input beat valid
//  S_axis_tready  out  1             input beat accepted
//  S_axis_tdata   in   AXIS_WIDTH    key/IV/payload data, byte lane 0 = tdata[7:0]
//  S_axis_tkeep   in   AXIS_WIDTH/8  byte enables, contiguous from lane 0
//  S_axis_tlast   in   1             last payload beat of message
//  S_axis_tuser   in   1             1=encrypt, 0=decrypt; sampled on first header beat
//  M_axis_tvalid  out  1             output beat valid
//  M_axis_tready  in   1             downstream ready
//  M_axis_tdata   out  AXIS_WIDTH    block-aligned data
//  M_axis_tkeep   out  AXIS_WIDTH/8  all ones on every valid beat
//  M_axis_tlast   out  1             last beat of last block
//  M_axis_tuser   out  1             encrypt bit, held constant for whole packet
//  Err_len        out  1             1-cycle pulse: decrypt payload not block multiple
// BEHAVIOUR
//  Reset: M_axis_tvalid/tlast/tuser/Err_len=0, tdata/tkeep=0, state ST_HEADER, cnts=0.
//  Output is one register slice: beat accepted at cycle t appears on M at t+1.
//  M holds data stable while tvalid & !tready. S_tready = (!M_tvalid | M_tready)
//   & state!=ST_PAD.
//  HDR_BEATS=(256+128)/AXIS_WIDTH (6 or 3); header beats forwarded unchanged,
//   tkeep forced all ones, tlast forced 0.
//  ST_HEADER: count header beats; on last one -> ST_PAYLOAD. Latch enc_reg from
//   tuser on beat 0. tlast on last header beat = empty payload -> ST_PAD with
//   n=0 (encrypt: one 0x10 block; decrypt: one zero block + Err_len).
//  ST_PAYLOAD: blk_word counts beats within a 16-byte block (wraps at
//   128/AXIS_WIDTH). Non-last beats forwarded as is (tkeep treated as full).
//   On tlast beat: k = leading-ones of tkeep (0 treated as full);
//   n = (blk_word*AXIS_WIDTH/8 + k) mod 16; p = 16-n (1..16).
//   Encrypt: lanes >=k filled with p. If the block is now complete and n!=0,
//    emit with M_tlast=1 -> ST_HEADER. Otherwise -> ST_PAD.
//   Decrypt: n==0 -> emit with M_tlast=1 -> ST_HEADER; else lanes >=k zeroed,
//    Err_len pulses in the cycle the beat is accepted, remaining beats -> ST_PAD.
//  ST_PAD: generate beats of fill byte (p if encrypt, 0x00 if decrypt) until
//   the block completes (1 or 2 beats at 64b); tlast on final one -> ST_HEADER.
//   S_tready=0 throughout.
//  pad_cnt = beats remaining: 2 when n==0 at 64b (full 0x10 block), else up to
//   block end. Advances only on M handshake.
//  Simultaneous: output slot refilled in the same cycle it drains (full throughput).
//  Rst mid-packet: drop all state, M_tvalid=0 next cycle, restart at ST_HEADER.
// STRUCTURE
//  aes_pkg: typedef enum {ST_HEADER, ST_PAYLOAD, ST_PAD} pad_state_t;
//   AES_BLOCK_BYTES=16, key/block lengths shared with aes_defines.svh.
//  Sub-module aes_axis_reg_slice (data/keep/last/user register + valid/ready).
//  Fill-lane mux and leading-ones count stay inline.
// TESTING
//  Enc, 20-byte payload (3 beats, last tkeep=0x0F) -> 4 beats; bytes 20..31=0x0C; tlast on beat 4.
//  Enc, 16-byte payload -> 2 data beats + 2 beats of 0x10; tlast on 4th; tuser=1 on all 10 beats.
//  Enc, 8-byte payload -> lanes of beat 2 all 0x08, beat 1 untouched; S_tready low during pad.
//  Dec, 32 bytes -> passthrough identical, tuser=0, Err_len never asserts.
//  Dec, 12 bytes (tkeep=0x0F on beat 2) -> Err_len 1 pulse, bytes 12..15=0x00, tlast.
//  Random M_tready backpressure on 100 random-length encrypt msgs -> no loss/dup.
//   Output matches ref PKCS#7, length = ceil((L+1)/16)*16.
//  Rst asserted mid-payload -> M_tvalid=0 next cycle; next packet correct.

Source files
------------

// File: rtl/aes256_cbc_pkcs7_pad_pkg.sv
// Shared AES sizing and pad-stage state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes256_cbc_pkcs7_pad_pkg;

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD
  } pad_state_t;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_BITS  = AES_BLOCK_BYTES * 8;
  localparam int AES_KEY_BITS    = 256;
  // Header is the 256-bit key followed by the 128-bit IV.
  localparam int AES_HDR_BITS    = AES_KEY_BITS + AES_BLOCK_BITS;

endpackage

// File: rtl/aes256_cbc_pkcs7_pad_reg_slice.sv
// Single-entry AXI-Stream register slice (data/keep/last/user + valid/ready).
// Latency: 1 cycle, full throughput (slot refills in the cycle it drains).
// Backpressure: in_rdy = !out_vld | out_rdy; output held stable while stalled.
// Ports: Clk, Rst (sync, active-high); in_* upstream beat; out_* downstream beat.
module aes256_cbc_pkcs7_pad_reg_slice #(
  parameter int W = 64
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [W-1:0]   in_dat,
  input  logic [W/8-1:0] in_keep,
  input  logic           in_last,
  input  logic           in_user,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [W-1:0]   out_dat,
  output logic [W/8-1:0] out_keep,
  output logic           out_last,
  output logic           out_user
);

  logic           vld_q, vld_d;
  logic [W-1:0]   dat_q, dat_d;
  logic [W/8-1:0] keep_q, keep_d;
  logic           last_q, last_d;
  logic           user_q, user_d;

  assign in_rdy = !vld_q || out_rdy;

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    keep_d = keep_q;
    last_d = last_q;
    user_d = user_q;
    if (in_rdy) begin
      vld_d = in_vld;
      if (in_vld) begin
        dat_d  = in_dat;
        keep_d = in_keep;
        last_d = in_last;
        user_d = in_user;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      user_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      keep_q <= keep_d;
      last_q <= last_d;
      user_q <= user_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_dat  = dat_q;
  assign out_keep = keep_q;
  assign out_last = last_q;
  assign out_user = user_q;

endmodule

// File: rtl/aes256_cbc_pkcs7_pad.sv
// Block-aligns one AXIS message (key, IV, payload): PKCS#7 pad on encrypt, zero-fill + Err_len on decrypt.
// Latency: 1 cycle S->M through one register slice; pad beats generated with S_axis_tready held low.
// Backpressure: S_axis_tready = (!M_axis_tvalid | M_axis_tready) & not padding; M held while stalled.
// Ports: Clk, Rst (sync, active-high); S_axis_* input stream (tuser=encrypt);
//        M_axis_* block-aligned output (tkeep all ones); Err_len pulses on a short decrypt payload.
module aes256_cbc_pkcs7_pad #(
  parameter int AXIS_WIDTH = 64
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    S_axis_tvalid,
  output logic                    S_axis_tready,
  input  logic [AXIS_WIDTH-1:0]   S_axis_tdata,
  input  logic [AXIS_WIDTH/8-1:0] S_axis_tkeep,
  input  logic                    S_axis_tlast,
  input  logic                    S_axis_tuser,
  output logic                    M_axis_tvalid,
  input  logic                    M_axis_tready,
  output logic [AXIS_WIDTH-1:0]   M_axis_tdata,
  output logic [AXIS_WIDTH/8-1:0] M_axis_tkeep,
  output logic                    M_axis_tlast,
  output logic                    M_axis_tuser,
  output logic                    Err_len
);

  import aes256_cbc_pkcs7_pad_pkg::*;

  localparam int BPB       = AXIS_WIDTH / 8;              // bytes per beat
  localparam int WPB       = AES_BLOCK_BITS / AXIS_WIDTH; // beats per AES block
  localparam int HDR_BEATS = AES_HDR_BITS / AXIS_WIDTH;

  generate
    if (AXIS_WIDTH != 64 && AXIS_WIDTH != 128) begin : g_bad_width
      $error("aes256_cbc_pkcs7_pad: AXIS_WIDTH must be 64 or 128");
    end
  endgenerate

  pad_state_t      state_q, state_d;
  logic [2:0]      hdr_cnt_q, hdr_cnt_d;
  logic            blk_word_q, blk_word_d;
  logic [1:0]      pad_cnt_q, pad_cnt_d;
  logic [7:0]      fill_q, fill_d;
  logic            enc_q, enc_d;

  logic                  slice_rdy, s_rdy, s_hs, err;
  logic                  sl_vld, sl_last, sl_user;
  logic [AXIS_WIDTH-1:0] sl_dat, last_dat;
  logic [4:0]            k, p;
  logic                  run;
  logic [3:0]            n;
  logic [7:0]            last_fill;
  logic [1:0]            last_pad;

  // Tail-beat arithmetic: valid byte count k, block fill n, pad value p,
  // and how many generated beats are still needed after this beat.
  always_comb begin
    k   = 5'd0;
    run = 1'b1;
    for (int i = 0; i < BPB; i++) begin
      if (run && S_axis_tkeep[i]) k = k + 5'd1;
      else                        run = 1'b0;
    end
    if (k == 5'd0) k = 5'(BPB);

    n = (blk_word_q ? 4'(BPB) : 4'd0) + k[3:0];
    p = 5'd16 - {1'b0, n};
    last_fill = enc_q ? {3'b000, p} : 8'h00;

    last_dat = S_axis_tdata;
    for (int i = 0; i < BPB; i++) begin
      if (5'(i) >= k) last_dat[8*i +: 8] = last_fill;
    end

    // A block-aligned encrypt message still needs a whole 0x10 block;
    // otherwise only the beats up to the block boundary are generated.
    if (n == 4'd0) last_pad = enc_q ? 2'(WPB) : 2'd0;
    else           last_pad = 2'(WPB) - 2'd1 - {1'b0, blk_word_q};
  end

  assign s_rdy = slice_rdy && (state_q != ST_PAD);
  assign s_hs  = S_axis_tvalid && s_rdy;

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    blk_word_d = blk_word_q;
    pad_cnt_d  = pad_cnt_q;
    fill_d     = fill_q;
    enc_d      = enc_q;
    sl_vld     = 1'b0;
    sl_dat     = S_axis_tdata;
    sl_last    = 1'b0;
    sl_user    = enc_q;
    err        = 1'b0;

    case (state_q)
      ST_HEADER: begin
        sl_vld = S_axis_tvalid;
        // Mode is not latched yet on the first header beat.
        if (hdr_cnt_q == 3'd0) sl_user = S_axis_tuser;
        if (s_hs) begin
          if (hdr_cnt_q == 3'd0) enc_d = S_axis_tuser;
          if (hdr_cnt_q == 3'(HDR_BEATS - 1)) begin
            hdr_cnt_d  = 3'd0;
            blk_word_d = 1'b0;
            if (S_axis_tlast) begin
              // Empty payload: emit one full fill block.
              state_d   = ST_PAD;
              pad_cnt_d = 2'(WPB);
              fill_d    = enc_q ? 8'h10 : 8'h00;
              err       = !enc_q;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        sl_vld = S_axis_tvalid;
        if (S_axis_tlast) begin
          sl_dat  = last_dat;
          sl_last = (last_pad == 2'd0);
        end
        if (s_hs) begin
          if (S_axis_tlast) begin
            err        = !enc_q && (n != 4'd0);
            blk_word_d = 1'b0;
            pad_cnt_d  = last_pad;
            fill_d     = last_fill;
            state_d    = (last_pad == 2'd0) ? ST_HEADER : ST_PAD;
          end else if (WPB > 1) begin
            blk_word_d = ~blk_word_q;
          end
        end
      end

      ST_PAD: begin
        sl_vld  = 1'b1;
        sl_dat  = {BPB{fill_q}};
        sl_last = (pad_cnt_q == 2'd1);
        if (slice_rdy) begin
          pad_cnt_d = pad_cnt_q - 2'd1;
          if (pad_cnt_q == 2'd1) state_d = ST_HEADER;
        end
      end

      default: state_d = ST_HEADER;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_HEADER;
      hdr_cnt_q  <= 3'd0;
      blk_word_q <= 1'b0;
      pad_cnt_q  <= 2'd0;
      fill_q     <= 8'h00;
      enc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      blk_word_q <= blk_word_d;
      pad_cnt_q  <= pad_cnt_d;
      fill_q     <= fill_d;
      enc_q      <= enc_d;
    end
  end

  aes256_cbc_pkcs7_pad_reg_slice #(.W(AXIS_WIDTH)) u_slice (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_vld   (sl_vld),
    .in_rdy   (slice_rdy),
    .in_dat   (sl_dat),
    .in_keep  ({BPB{1'b1}}),
    .in_last  (sl_last),
    .in_user  (sl_user),
    .out_vld  (M_axis_tvalid),
    .out_rdy  (M_axis_tready),
    .out_dat  (M_axis_tdata),
    .out_keep (M_axis_tkeep),
    .out_last (M_axis_tlast),
    .out_user (M_axis_tuser)
  );

  assign S_axis_tready = s_rdy;
  // Pulses in the cycle the offending beat is accepted on S.
  assign Err_len = err && !Rst;

endmodule

// File: tb/tb_aes256_cbc_pkcs7_pad.sv
module tb_aes256_cbc_pkcs7_pad;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        S_axis_tvalid = 1'b0;
  logic        S_axis_tready;
  logic [63:0] S_axis_tdata = '0;
  logic [7:0]  S_axis_tkeep = '0;
  logic        S_axis_tlast = 1'b0;
  logic        S_axis_tuser = 1'b0;
  logic        M_axis_tvalid;
  logic        M_axis_tready;
  logic [63:0] M_axis_tdata;
  logic [7:0]  M_axis_tkeep;
  logic        M_axis_tlast;
  logic        M_axis_tuser;
  logic        Err_len;

  aes256_cbc_pkcs7_pad #(.AXIS_WIDTH(64)) dut (
    .Clk(Clk), .Rst(Rst),
    .S_axis_tvalid(S_axis_tvalid), .S_axis_tready(S_axis_tready),
    .S_axis_tdata(S_axis_tdata), .S_axis_tkeep(S_axis_tkeep),
    .S_axis_tlast(S_axis_tlast), .S_axis_tuser(S_axis_tuser),
    .M_axis_tvalid(M_axis_tvalid), .M_axis_tready(M_axis_tready),
    .M_axis_tdata(M_axis_tdata), .M_axis_tkeep(M_axis_tkeep),
    .M_axis_tlast(M_axis_tlast), .M_axis_tuser(M_axis_tuser),
    .Err_len(Err_len)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] cap_d[$];
  logic        cap_l[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  bit          chk_en = 1'b0;
  bit          bp_en = 1'b0;
  logic [7:0]  hdr[48];
  logic [7:0]  pay[64];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: full output byte stream from the PKCS#7 / zero-fill rules, cut into 8-byte beats.
  task automatic model_push(input bit enc, input int len);
    logic [7:0] ob[$];
    beat_t      e;
    int         nbeats;
    int         pv;
    for (int i = 0; i < 48; i++) ob.push_back(hdr[i]);
    for (int i = 0; i < len; i++) ob.push_back(pay[i]);
    if (enc) begin
      pv = 16 - (len % 16);
      for (int i = 0; i < pv; i++) ob.push_back(8'(pv));
    end else begin
      if (len == 0 || (len % 16) != 0) exp_err++;
      if (len == 0) repeat (16) ob.push_back(8'h00);
      while ((ob.size() % 16) != 0) ob.push_back(8'h00);
    end
    nbeats = ob.size() / 8;
    for (int b = 0; b < nbeats; b++) begin
      e.d = '0;
      for (int j = 0; j < 8; j++) e.d[8*j +: 8] = ob[8*b + j];
      e.l = (b == nbeats - 1);
      e.u = enc;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every valid output cycle is checked against the head of the model queue.
  initial begin
    forever begin
      @(negedge Clk);
      if (chk_en && !Rst) begin
        if (Err_len) err_seen++;
        if (M_axis_tvalid) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %h with no beat expected", M_axis_tdata);
          end else begin
            chk("beat_data", M_axis_tdata, exp_q[0].d);
            chk("beat_keep_last_user", {54'd0, M_axis_tkeep, M_axis_tlast, M_axis_tuser},
                {54'd0, 8'hFF, exp_q[0].l, exp_q[0].u});
            if (M_axis_tready) begin
              cap_d.push_back(M_axis_tdata);
              cap_l.push_back(M_axis_tlast);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // Downstream ready: constant high or random stalls.
  initial begin
    M_axis_tready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      M_axis_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] kp, input logic l, input logic u);
    int t = 0;
    S_axis_tvalid = 1'b1;
    S_axis_tdata  = d;
    S_axis_tkeep  = kp;
    S_axis_tlast  = l;
    S_axis_tuser  = u;
    while (1) begin
      @(negedge Clk);
      if (S_axis_tready) break;
      t++;
      if (t > 1000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL s_tready_timeout: got no ready in %0d cycles, want ready", t);
        break;
      end
    end
    @(posedge Clk);
    #1;
    S_axis_tvalid = 1'b0;
    S_axis_tlast  = 1'b0;
  endtask

  task automatic send_msg(input bit enc, input int len, input bit use_model);
    logic [63:0] d;
    logic [7:0]  kp;
    int          nb;
    int          cnt;
    for (int i = 0; i < 48; i++) hdr[i] = 8'($urandom);
    if (use_model) model_push(enc, len);
    cap_d.delete();
    cap_l.delete();
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 8; j++) d[8*j +: 8] = hdr[8*b + j];
      drive_beat(d, 8'hFF, (b == 5) && (len == 0), enc);
    end
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++)
        d[8*j +: 8] = (8*b + j < len) ? pay[8*b + j] : 8'($urandom);
      cnt = (len - 8*b > 8) ? 8 : len - 8*b;
      kp  = 8'((1 << cnt) - 1);
      drive_beat(d, kp, b == nb - 1, enc);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge Clk);
      t++;
    end
    chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic start_test();
    err_seen = 0;
    exp_err  = 0;
    for (int j = 0; j < 64; j++) pay[j] = 8'(8'hA0 + j);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_tvalid", 64'(M_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(M_axis_tlast), 64'd0);
    chk("rst_tuser", 64'(M_axis_tuser), 64'd0);
    chk("rst_err", 64'(Err_len), 64'd0);
    chk("rst_tdata", M_axis_tdata, 64'd0);
    chk("rst_tkeep", 64'(M_axis_tkeep), 64'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk_en = 1'b1;

    // Encrypt 20 bytes: 3 payload beats -> 4 beats, bytes 20..31 = 0x0C
    start_test();
    send_msg(1'b1, 20, 1'b1);
    drain("enc20");
    chk("enc20_beats", 64'(cap_d.size()), 64'd10);
    chk("enc20_b8", cap_d[8], 64'h0C0C0C0C_B3B2B1B0);
    chk("enc20_b9", cap_d[9], 64'h0C0C0C0C_0C0C0C0C);
    chk("enc20_last9", 64'(cap_l[9]), 64'd1);
    chk("enc20_err", 64'(err_seen), 64'd0);

    // Encrypt 16 bytes: full 0x10 block appended
    start_test();
    send_msg(1'b1, 16, 1'b1);
    drain("enc16");
    chk("enc16_beats", 64'(cap_d.size()), 64'd10);
    chk("enc16_b7", cap_d[7], 64'hAFAEADAC_ABAAA9A8);
    chk("enc16_b8", cap_d[8], 64'h10101010_10101010);
    chk("enc16_last8", 64'(cap_l[8]), 64'd0);
    chk("enc16_b9", cap_d[9], 64'h10101010_10101010);

    // Encrypt 8 bytes: one pad beat of 0x08, S_tready low while it is generated
    start_test();
    send_msg(1'b1, 8, 1'b1);
    @(negedge Clk);
    chk("enc8_s_tready_pad", 64'(S_axis_tready), 64'd0);
    drain("enc8");
    chk("enc8_beats", 64'(cap_d.size()), 64'd8);
    chk("enc8_b6", cap_d[6], 64'hA7A6A5A4_A3A2A1A0);
    chk("enc8_b7", cap_d[7], 64'h08080808_08080808);

    // Decrypt 32 bytes: passthrough, no error
    start_test();
    send_msg(1'b0, 32, 1'b1);
    drain("dec32");
    chk("dec32_beats", 64'(cap_d.size()), 64'd10);
    chk("dec32_b9", cap_d[9], 64'hBFBEBDBC_BBBAB9B8);
    chk("dec32_err", 64'(err_seen), 64'd0);

    // Decrypt 12 bytes: zero-fill lanes 12..15, one error pulse
    start_test();
    send_msg(1'b0, 12, 1'b1);
    drain("dec12");
    chk("dec12_beats", 64'(cap_d.size()), 64'd8);
    chk("dec12_b7", cap_d[7], 64'h00000000_ABAAA9A8);
    chk("dec12_last7", 64'(cap_l[7]), 64'd1);
    chk("dec12_err", 64'(err_seen), 64'd1);

    // Decrypt empty payload: one zero block, one error pulse
    start_test();
    send_msg(1'b0, 0, 1'b1);
    drain("dec0");
    chk("dec0_beats", 64'(cap_d.size()), 64'd8);
    chk("dec0_b7", cap_d[7], 64'd0);
    chk("dec0_err", 64'(err_seen), 64'd1);

    // 100 random-length encrypt messages under random backpressure
    start_test();
    bp_en = 1'b1;
    for (int m = 0; m < 100; m++) begin
      int len;
      len = $urandom_range(0, 40);
      for (int j = 0; j < 64; j++) pay[j] = 8'($urandom);
      send_msg(1'b1, len, 1'b1);
      drain("rnd");
      chk("rnd_len_beats", 64'(cap_d.size()), 64'(6 + ((len + 16) / 16) * 2));
    end
    chk("rnd_err", 64'(err_seen), 64'(exp_err));
    bp_en = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Reset in the middle of a payload, then a clean packet
    chk_en = 1'b0;
    start_test();
    for (int b = 0; b < 6; b++) drive_beat(64'h1111_2222_3333_4444 + 64'(b), 8'hFF, 1'b0, 1'b1);
    drive_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, 1'b1);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("midrst_tvalid", 64'(M_axis_tvalid), 64'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    exp_q.delete();
    chk_en = 1'b1;
    send_msg(1'b1, 20, 1'b1);
    drain("post_rst");
    chk("post_rst_beats", 64'(cap_d.size()), 64'd10);
    chk("post_rst_b9", cap_d[9], 64'h0C0C0C0C_0C0C0C0C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
